gpio_bank: RTL and testbench

GPIO_BANK -- requirements
Module: gpio_bank

---
 rtl/gpio_bank.sv | 143 ++++++++++++++
 tb/tb_gpio_bank.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank.sv
// gpio_bank: CPU-mapped bank of GPIO ports with synchronised inputs; edge flags,
// mask and irq exist only when the macro GPIO_BANK_IRQ_EN is defined.
module gpio_bank #(
  parameter int          WIDTH     = 8,
  parameter int          PORTS     = 1,
  parameter logic [15:0] BASE_ADDR = 16'h0400
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [15:0]            addr,
  input  logic [7:0]             data_in,
  input  logic                   write_enable,
  output logic [7:0]             data_out,
  output logic                   hit,
  input  logic [PORTS*WIDTH-1:0] pin_in,
  output logic [PORTS*WIDTH-1:0] pin_out,
  output logic [PORTS*WIDTH-1:0] pin_oe,
  output logic                   irq
);

  localparam logic [2:0] R_OUT  = 3'd0;
  localparam logic [2:0] R_DIR  = 3'd1;
  localparam logic [2:0] R_IN   = 3'd2;
  localparam logic [2:0] R_FLAG = 3'd3;
  localparam logic [2:0] R_MASK = 3'd4;
  localparam logic [2:0] R_EDGE = 3'd5;

  logic [1:0] port;
  logic [2:0] reg_sel;
  logic       window_hit;
  logic [7:0] rd_port [PORTS];
  logic [7:0] rd_data;

  assign port       = addr[4:3];
  assign reg_sel    = addr[2:0];
  assign window_hit = (addr[15:5] == BASE_ADDR[15:5]) && ({1'b0, port} < 3'(PORTS));

`ifdef GPIO_BANK_IRQ_EN
  logic [1:0]       settle_cnt;
  logic             settled;
  logic [PORTS-1:0] pend;

  // Flags stay off until the synchroniser and previous-value flops hold real pin data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt <= '0;
      irq        <= 1'b0;
    end else begin
      if (settle_cnt != 2'd3) settle_cnt <= settle_cnt + 2'd1;
      irq <= |pend;
    end
  end

  assign settled = (settle_cnt == 2'd3);
`else
  assign irq = 1'b0;
`endif

  for (genvar g = 0; g < PORTS; g++) begin : g_port
    logic [WIDTH-1:0] port_out, port_dir, sync_meta, sync_val;
    logic             wr;
    logic [7:0]       rd;

    assign wr = write_enable && window_hit && (port == 2'(g));

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        port_out  <= '0;
        port_dir  <= '0;
        sync_meta <= '0;
        sync_val  <= '0;
      end else begin
        sync_meta <= pin_in[g*WIDTH +: WIDTH];
        sync_val  <= sync_meta;
        if (wr && reg_sel == R_OUT) port_out <= data_in[WIDTH-1:0];
        if (wr && reg_sel == R_DIR) port_dir <= data_in[WIDTH-1:0];
      end
    end

`ifdef GPIO_BANK_IRQ_EN
    logic [WIDTH-1:0] prev_val, flag, mask, edge_sel, edge_seen, clr;

    // EDGE bit 0 selects rising, 1 selects falling for that pin.
    assign edge_seen = settled ? ((sync_val & ~prev_val & ~edge_sel) |
                                  (~sync_val & prev_val & edge_sel)) : '0;
    assign clr       = (wr && reg_sel == R_FLAG) ? data_in[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        prev_val <= '0;
        flag     <= '0;
        mask     <= '0;
        edge_sel <= '0;
      end else begin
        prev_val <= sync_val;
        flag     <= (flag & ~clr) | edge_seen;
        if (wr && reg_sel == R_MASK) mask     <= data_in[WIDTH-1:0];
        if (wr && reg_sel == R_EDGE) edge_sel <= data_in[WIDTH-1:0];
      end
    end

    assign pend[g] = |(flag & mask);
`endif

    // NOTE: default assignment first so no path leaves rd unassigned (no latch).
    always_comb begin
      rd = '0;
      case (reg_sel)
        R_OUT:  rd[WIDTH-1:0] = port_out;
        R_DIR:  rd[WIDTH-1:0] = port_dir;
        R_IN:   rd[WIDTH-1:0] = sync_val;
`ifdef GPIO_BANK_IRQ_EN
        R_FLAG: rd[WIDTH-1:0] = flag;
        R_MASK: rd[WIDTH-1:0] = mask;
        R_EDGE: rd[WIDTH-1:0] = edge_sel;
`endif
        default: ;
      endcase
    end

    assign rd_port[g]                 = rd;
    assign pin_out[g*WIDTH +: WIDTH] = port_out;
    assign pin_oe[g*WIDTH +: WIDTH]  = port_dir;
  end

  always_comb begin
    rd_data = '0;
    for (int q = 0; q < PORTS; q++)
      if (port == 2'(q)) rd_data = rd_port[q];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit      <= 1'b0;
      data_out <= '0;
    end else begin
      hit      <= window_hit;
      data_out <= window_hit ? rd_data : 8'h00;
    end
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank (WIDTH=8, PORTS=2): byte-level register/pin-history model
// checked every cycle, plus directed reads with hand-computed values.
module tb_gpio_bank;

  localparam int          W    = 8;
  localparam int          P    = 2;
  localparam logic [15:0] BASE = 16'h0400;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [15:0]    addr = 16'h0000;
  logic [7:0]     data_in = 8'h00;
  logic           write_enable = 1'b0;
  logic [7:0]     data_out;
  logic           hit;
  logic [P*W-1:0] pin_in = '0;
  logic [P*W-1:0] pin_out;
  logic [P*W-1:0] pin_oe;
  logic           irq;

  int checks = 0;
  int errors = 0;
  logic run = 1'b0;

  gpio_bank #(.WIDTH(W), .PORTS(P), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .data_in(data_in),
    .write_enable(write_enable), .data_out(data_out), .hit(hit),
    .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: register bytes per port and the pin values seen at recent edges.
  logic [7:0]     m_out [P], m_dir [P], m_flag [P], m_mask [P], m_edge [P];
  logic [P*W-1:0] hist [$];
  logic [P*W-1:0] h_now, h_old;
  int             n_edges, mp;
  logic [2:0]     mr;
  logic           m_hit, m_irq;
  logic [7:0]     m_dout, s, v, ev, clr;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int q = 0; q < P; q++) begin
        m_out[q] = 0; m_dir[q] = 0; m_flag[q] = 0; m_mask[q] = 0; m_edge[q] = 0;
      end
      hist = '{0, 0, 0};
      n_edges = 0; m_hit = 0; m_dout = 0; m_irq = 0;
    end else begin
      n_edges++;
      h_now = hist[1];   // pin value visible to the bank: sampled two edges ago
      h_old = hist[2];
      m_irq = 0;
`ifdef GPIO_BANK_IRQ_EN
      for (int q = 0; q < P; q++) m_irq |= |(m_flag[q] & m_mask[q]);
`endif
      mp = int'(addr[4:3]);
      mr = addr[2:0];
      m_hit = (addr[15:5] == BASE[15:5]) && (mp < P);
      m_dout = 0;
      if (m_hit) begin
        case (mr)
          3'd0: m_dout = m_out[mp];
          3'd1: m_dout = m_dir[mp];
          3'd2: m_dout = h_now[mp*8 +: 8];
`ifdef GPIO_BANK_IRQ_EN
          3'd3: m_dout = m_flag[mp];
          3'd4: m_dout = m_mask[mp];
          3'd5: m_dout = m_edge[mp];
`endif
          default: m_dout = 0;
        endcase
      end
`ifdef GPIO_BANK_IRQ_EN
      for (int q = 0; q < P; q++) begin
        s = h_now[q*8 +: 8];
        v = h_old[q*8 +: 8];
        ev = (n_edges >= 4) ? ((s & ~v & ~m_edge[q]) | (~s & v & m_edge[q])) : 8'h00;
        clr = (write_enable && m_hit && mp == q && mr == 3'd3) ? data_in : 8'h00;
        m_flag[q] = (m_flag[q] & ~clr) | ev;
      end
`endif
      if (write_enable && m_hit) begin
        case (mr)
          3'd0: m_out[mp] = data_in;
          3'd1: m_dir[mp] = data_in;
`ifdef GPIO_BANK_IRQ_EN
          3'd4: m_mask[mp] = data_in;
          3'd5: m_edge[mp] = data_in;
`endif
          default: ;
        endcase
      end
      hist.push_front(pin_in);
      void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    if (run) begin
      check("hit", hit, m_hit);
      check("data_out", data_out, m_dout);
      check("pin_out", pin_out, {m_out[1], m_out[0]});
      check("pin_oe", pin_oe, {m_dir[1], m_dir[0]});
      check("irq", irq, m_irq);
    end
  end

  task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic we);
    addr = a; data_in = d; write_enable = we;
    @(posedge clk);
    @(negedge clk);
    write_enable = 1'b0;
    addr = 16'h0000;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(16'h0000, 8'h00, 1'b0);
  endtask

  task automatic rd(input string name, input logic [15:0] a, input logic [7:0] exp);
    cyc(a, 8'h00, 1'b0);
    check(name, data_out, exp);
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    run = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_pin_oe", pin_oe, 16'h0000);
    check("rst_pin_out", pin_out, 16'h0000);
    check("rst_irq", irq, 1'b0);

    rd("rd_out_reset", 16'h0400, 8'h00);
    check("rd_out_reset_hit", hit, 1'b1);

    cyc(16'h0400, 8'hA5, 1'b1);
    cyc(16'h0401, 8'hFF, 1'b1);
    check("pin_out_lo", pin_out[7:0], 8'hA5);
    check("pin_oe_lo", pin_oe[7:0], 8'hFF);
    rd("rd_out", 16'h0400, 8'hA5);
    rd("rd_dir", 16'h0401, 8'hFF);

    cyc(16'h0408, 8'h3C, 1'b1);
    check("pin_out_p1", pin_out, 16'h3CA5);
    rd("rd_p1_out", 16'h0408, 8'h3C);
    rd("rd_miss_p2", 16'h0410, 8'h00);
    check("miss_p2_hit", hit, 1'b0);
    cyc(16'h0406, 8'h55, 1'b1);
    rd("rd_reserved", 16'h0406, 8'h00);
    check("reserved_hit", hit, 1'b1);
    rd("rd_miss_hi", 16'h0420, 8'h00);
    check("miss_hi_hit", hit, 1'b0);

    pin_in = 16'hC300;
    idle(3);
    rd("rd_in_p1", 16'h040A, 8'hC3);
    rd("rd_in_p0", 16'h0402, 8'h00);

`ifdef GPIO_BANK_IRQ_EN
    cyc(16'h040B, 8'hFF, 1'b1);
    cyc(16'h0404, 8'h01, 1'b1);
    pin_in[0] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      if (irq === 1'b1 && lat == 0) lat = i;
    end
    check("irq_within_4", (lat >= 1 && lat <= 4), 1'b1);
    rd("rd_in_pin0", 16'h0402, 8'h01);
    rd("rd_flag_rise", 16'h0403, 8'h01);

    pin_in[0] = 1'b0;
    idle(4);
    pin_in[0] = 1'b1;
    idle(2);
    cyc(16'h0403, 8'h01, 1'b1);
    rd("flag_set_wins", 16'h0403, 8'h01);
    cyc(16'h0403, 8'h01, 1'b1);
    check("irq_hold_after_clear", irq, 1'b1);
    rd("flag_cleared", 16'h0403, 8'h00);
    check("irq_dropped", irq, 1'b0);

    cyc(16'h0405, 8'h02, 1'b1);
    pin_in[1] = 1'b1;
    idle(4);
    rd("no_rise_on_fall_pin", 16'h0403, 8'h00);
    pin_in[1] = 1'b0;
    idle(4);
    rd("fall_flag", 16'h0403, 8'h02);
    check("irq_masked", irq, 1'b0);
    cyc(16'h0404, 8'h03, 1'b1);
    idle(1);
    check("irq_unmasked", irq, 1'b1);

    cyc(16'h0405, 8'h03, 1'b1);
    idle(2);
    rd("edge_change_no_flag", 16'h0403, 8'h02);
    cyc(16'h0403, 8'h02, 1'b1);
    pin_in[0] = 1'b0;
    idle(4);
    rd("fall_flag_pin0", 16'h0403, 8'h01);
    cyc(16'h0403, 8'hFF, 1'b1);
`else
    cyc(16'h0404, 8'hFF, 1'b1);
    pin_in[0] = 1'b1;
    idle(4);
    pin_in[0] = 1'b0;
    idle(4);
    rd("noirq_flag", 16'h0403, 8'h00);
    rd("noirq_mask", 16'h0404, 8'h00);
    check("noirq_irq", irq, 1'b0);
`endif

    pin_in = 16'hFFFF;
    addr = 16'h0400; data_in = 8'h77; write_enable = 1'b1;
    #2 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    write_enable = 1'b0;
    addr = 16'h0000;
    reset_n = 1'b1;
    check("midwrite_pin_out", pin_out, 16'h0000);
    rd("midwrite_out", 16'h0400, 8'h00);
    idle(6);
    rd("no_spurious_flag", 16'h0403, 8'h00);
    rd("in_after_reset", 16'h0402, 8'hFF);
    check("irq_after_reset", irq, 1'b0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
